// File: rtl/nes_cpu_bus_driver_if.sv
// nes_cpu_bus_driver_if: command/response handshake plus the cartridge CPU bus pins.
// slave = the bus driver itself; master = host logic together with the cartridge side.
interface nes_cpu_bus_driver_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_data;
   logic [7:0]  cmd_count;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic        cmd_done;
   logic        busy;
   logic        m2;
   logic        romsel;
   logic        cpu_rw;
   logic [14:0] cpu_addr;
   logic [7:0]  cpu_data_out;
   logic        cpu_data_oe;
   logic [7:0]  cpu_data_in;

   modport slave (
      input  cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_count, cpu_data_in,
      output cmd_ready, rsp_valid, rsp_data, cmd_done, busy,
             m2, romsel, cpu_rw, cpu_addr, cpu_data_out, cpu_data_oe
   );

   modport master (
      output cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_count, cpu_data_in,
      input  cmd_ready, rsp_valid, rsp_data, cmd_done, busy,
             m2, romsel, cpu_rw, cpu_addr, cpu_data_out, cpu_data_oe
   );
endinterface

// File: rtl/nes_cpu_bus_driver.sv
// nes_cpu_bus_driver: turns queued commands into NES CPU bus cycles, bursts auto-increment.
// Define NES_M2_FREE_RUN_EN to keep m2 running with dummy read cycles while idle.
module nes_cpu_bus_driver #(
   parameter int PHI_LOW  = 3,
   parameter int PHI_HIGH = 3
) (
   input logic                 clk,
   input logic                 reset,
   nes_cpu_bus_driver_if.slave bus
);
`ifdef NES_M2_FREE_RUN_EN
   localparam bit FREE_RUN = 1'b1;
`else
   localparam bit FREE_RUN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

   localparam logic [7:0] LOW_LAST  = 8'(PHI_LOW - 1);
   localparam logic [7:0] HIGH_LAST = 8'(PHI_HIGH - 1);

   state_t      state, state_nxt;
   logic [7:0]  phase, phase_nxt;
   logic [15:0] addr, addr_nxt;
   logic [7:0]  data, data_nxt;
   logic [7:0]  remaining, remaining_nxt;
   logic        write, write_nxt;
   logic        dummy, dummy_nxt;
   logic        capture;
   logic        active;

   logic        m2_nxt, romsel_nxt, cpu_rw_nxt, oe_nxt;
   logic        ready_nxt, busy_nxt, rsp_valid_nxt, done_nxt;
   logic [14:0] cpu_addr_nxt;
   logic [7:0]  cpu_data_out_nxt;

   // Outputs are decoded from the next state so every pin is a flop that lines up with its state.
   always_comb begin
      // NOTE: every signal gets a default first so no path through the case can infer a latch.
      state_nxt     = state;
      phase_nxt     = phase;
      addr_nxt      = addr;
      data_nxt      = data;
      remaining_nxt = remaining;
      write_nxt     = write;
      dummy_nxt     = dummy;
      capture       = 1'b0;

      unique case (state)
         IDLE: begin
            phase_nxt = '0;
            if (bus.cmd_valid && bus.cmd_ready) begin
               state_nxt     = SETUP;
               addr_nxt      = bus.cmd_addr;
               data_nxt      = bus.cmd_data;
               write_nxt     = bus.cmd_write;
               remaining_nxt = bus.cmd_count;
               dummy_nxt     = 1'b0;
            end else if (FREE_RUN) begin
               state_nxt = SETUP;
               dummy_nxt = 1'b1;
            end
         end
         SETUP: begin
            if (phase == LOW_LAST) begin
               state_nxt = STROBE;
               phase_nxt = '0;
            end else begin
               phase_nxt = phase + 8'd1;
            end
         end
         STROBE: begin
            if (phase == HIGH_LAST) begin
               // A dummy cycle's HOLD clock is the IDLE accept slot itself.
               state_nxt = dummy ? IDLE : HOLD;
               phase_nxt = '0;
               capture   = !dummy && !write;
            end else begin
               phase_nxt = phase + 8'd1;
            end
         end
         HOLD: begin
            addr_nxt = addr + 16'd1;
            if (remaining == 8'd0) begin
               state_nxt = FREE_RUN ? SETUP : IDLE;
               dummy_nxt = FREE_RUN;
            end else begin
               state_nxt     = SETUP;
               remaining_nxt = remaining - 8'd1;
            end
         end
      endcase

      active           = (state_nxt != IDLE) && !dummy_nxt;
      m2_nxt           = (state_nxt == STROBE);
      romsel_nxt       = !(active && m2_nxt && addr_nxt[15]);
      cpu_rw_nxt       = !(active && write_nxt);
      oe_nxt           = active && write_nxt && (state_nxt == STROBE || state_nxt == HOLD);
      ready_nxt        = (state_nxt == IDLE);
      busy_nxt         = active;
      rsp_valid_nxt    = active && !write_nxt && (state_nxt == HOLD);
      done_nxt         = active && (state_nxt == HOLD) && (remaining_nxt == 8'd0);
      cpu_addr_nxt     = active ? addr_nxt[14:0] : (dummy_nxt ? 15'd0 : bus.cpu_addr);
      cpu_data_out_nxt = (active && write_nxt) ? data_nxt : bus.cpu_data_out;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= IDLE;
         phase            <= '0;
         addr             <= '0;
         data             <= '0;
         remaining        <= '0;
         write            <= 1'b0;
         dummy            <= 1'b0;
         bus.m2           <= 1'b0;
         bus.romsel       <= 1'b1;
         bus.cpu_rw       <= 1'b1;
         bus.cpu_addr     <= '0;
         bus.cpu_data_out <= '0;
         bus.cpu_data_oe  <= 1'b0;
         bus.cmd_ready    <= 1'b1;
         bus.busy         <= 1'b0;
         bus.rsp_valid    <= 1'b0;
         bus.rsp_data     <= '0;
         bus.cmd_done     <= 1'b0;
      end else begin
         state            <= state_nxt;
         phase            <= phase_nxt;
         addr             <= addr_nxt;
         data             <= data_nxt;
         remaining        <= remaining_nxt;
         write            <= write_nxt;
         dummy            <= dummy_nxt;
         bus.m2           <= m2_nxt;
         bus.romsel       <= romsel_nxt;
         bus.cpu_rw       <= cpu_rw_nxt;
         bus.cpu_addr     <= cpu_addr_nxt;
         bus.cpu_data_out <= cpu_data_out_nxt;
         bus.cpu_data_oe  <= oe_nxt;
         bus.cmd_ready    <= ready_nxt;
         bus.busy         <= busy_nxt;
         bus.rsp_valid    <= rsp_valid_nxt;
         bus.cmd_done     <= done_nxt;
         if (capture) bus.rsp_data <= bus.cpu_data_in;
      end
   end
endmodule
